rf_wr_arbiter: RTL and testbench
================================

// Module: rf_wr_arbiter
// PURPOSE
//  Shares the single register-file write port between the in-order WB stage and a
//  multi-cycle unit (MUL/DIV). Buffers MC results, tracks MC destinations in a
//  scoreboard, raises an ID-stage hazard stall, and prevents MC starvation.
//  Sits between WB/MC units and the RF write port (RFWr/WrDtAdr/WrDt).
// PARAMETERS
//  DEPTH         2  MC result buffer entries (power of 2, >=2)
//  STARVE_LIMIT  4  consecutive cycles a buffered head may lose to WB before forced grant
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  wb_we        in   1   WB stage write request
//  wb_rd        in   5   WB destination
//  wb_data      in   32  WB data
//  wb_hold      out  1   WB write not performed this cycle; pipeline must hold WB stage
//  mc_issue     in   1   MC op issued this cycle
//  mc_issue_rd  in   5   destination of issued MC op
//  mc_valid     in   1   MC result valid
//  mc_ready     out  1   buffer can accept MC result
//  mc_rd        in   5   MC result destination
//  mc_data      in   32  MC result data
//  rs1, rs2     in   5   ID-stage source registers
//  hazard_stall out  1   rs1/rs2 (nonzero) is scoreboard-busy
//  RFWr         out  1   RF write enable
//  WrDtAdr      out  5   RF write address
//  WrDt         out  32  RF write data
//  pend_cnt     out  $clog2(DEPTH)+1  buffered entries
// BEHAVIOUR
//  - Reset (async, rst_n=0): buffer empty, pend_cnt=0, scoreboard all clear, starve
//    counter=0; while rst_n=0 force RFWr=0, mc_ready=0, wb_hold=0, hazard_stall=0.
//    Reset mid-operation drops buffered results and busy bits.
//  - MC transfer on posedge when mc_valid&&mc_ready; pushes {mc_rd,mc_data} at tail.
//    mc_rd==0: accepted, not stored. mc_ready = !full (registered count; a same-cycle
//    pop does not make a full buffer ready).
//  - Port grant (combinational, same cycle, RF commits at its own edge):
//    1) head waiting and starve==STARVE_LIMIT -> grant buffer head, wb_hold=wb_we.
//    2) else wb_we && wb_rd!=0 -> grant WB.
//    3) else buffer nonempty -> grant head (pop at posedge).
//    4) else RFWr=0, WrDtAdr=0, WrDt=0. wb_we with wb_rd==0: no write, no hold.
//  - Starve counter: +1 each cycle head nonempty and WB wins; clears on pop or when empty;
//    saturates at STARVE_LIMIT.
//  - Scoreboard (32 bits, bit0 hardwired 0): set at posedge on mc_issue (rd!=0); cleared
//    when that rd is popped to RF. Set and clear same rd same cycle -> set wins.
//  - hazard_stall = busy[rs1]|busy[rs2], combinational from registered busy bits.
//  - Minimum MC latency: accepted edge N, RF write in cycle N+1. Buffer pointers wrap mod DEPTH.
// CONFIGURATION
//  ARB_BYPASS_EN defined: when buffer empty, no WB grant and mc_valid with mc_rd!=0,
//    MC result drives RF port in the same cycle (not stored; busy bit cleared).
//  Undefined: all MC results pass through buffer; min latency one cycle.
// TESTING
//  1. Reset: rst_n=0 mid-stream with 2 entries -> pend_cnt=0, RFWr=0, mc_ready=0; after
//     release mc_ready=1, all busy clear.
//  2. WB only: wb_we=1 rd=5 data=0xDEADBEEF -> RFWr=1, WrDtAdr=5, WrDt=0xDEADBEEF, wb_hold=0.
//  3. Contention: push MC rd=7 0x11 while wb_we busy 6 cycles -> WB wins 4 cycles, 5th
//     cycle WrDtAdr=7 WrDt=0x11, wb_hold=1; WB rewrites next cycle.
//  4. Full: DEPTH=2, push 2 results under continuous WB -> mc_ready=0, pend_cnt=2;
//     third mc_valid held until a pop.
//  5. Scoreboard: mc_issue rd=9, rs1=9 -> hazard_stall=1 until rd 9 written; rd=0 issue
//     -> never stalls; issue rd=9 same cycle as pop of rd=9 -> busy stays 1.
//  6. ARB_BYPASS_EN: idle port, mc_valid rd=3 0x55 -> RF write same cycle, pend_cnt=0;
//     without macro write occurs next cycle.

Source files
------------

// File: rtl/rf_wr_arbiter_if.sv
// Register-file write-port arbitration bundle: WB request, MC issue/result
// handshake, ID-stage source operands and the shared RF write port.
// The master side is the pipeline (WB, MC unit, ID); the slave is the arbiter.
interface rf_wr_arbiter_if #(
  parameter int DEPTH = 2
);
  logic                     wb_we;
  logic [4:0]               wb_rd;
  logic [31:0]              wb_data;
  logic                     wb_hold;
  logic                     mc_issue;
  logic [4:0]               mc_issue_rd;
  logic                     mc_valid;
  logic                     mc_ready;
  logic [4:0]               mc_rd;
  logic [31:0]              mc_data;
  logic [4:0]               rs1;
  logic [4:0]               rs2;
  logic                     hazard_stall;
  logic                     RFWr;
  logic [4:0]               WrDtAdr;
  logic [31:0]              WrDt;
  logic [$clog2(DEPTH):0]   pend_cnt;

  modport master (
    output wb_we, wb_rd, wb_data, mc_issue, mc_issue_rd,
           mc_valid, mc_rd, mc_data, rs1, rs2,
    input  wb_hold, mc_ready, hazard_stall, RFWr, WrDtAdr, WrDt, pend_cnt
  );

  modport slave (
    input  wb_we, wb_rd, wb_data, mc_issue, mc_issue_rd,
           mc_valid, mc_rd, mc_data, rs1, rs2,
    output wb_hold, mc_ready, hazard_stall, RFWr, WrDtAdr, WrDt, pend_cnt
  );
endinterface

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: shares the single RF write port between the in-order WB stage
// and a multi-cycle (MUL/DIV) unit. MC results are queued in a small FIFO, MC
// destinations are tracked in a busy scoreboard for ID hazard detection, and a
// starvation counter forces the buffered head onto the port after STARVE_LIMIT
// consecutive losses to WB.
// Optional feature macro ARB_BYPASS_EN: an MC result may drive the RF port in
// its arrival cycle when the buffer is empty and WB is not writing.
module rf_wr_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  rf_wr_arbiter_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [4:0]    bufRd   [DEPTH];
  logic [31:0]   bufData [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve;
  logic [31:0]   busy;

  logic          headValid;
  logic          full;
  logic          wbReq;
  logic          accept;
  logic          push;
  logic          pop;
  logic          bypass;
  logic          wbWin;
  logic [31:0]   setMask;
  logic [31:0]   clrMask;

  // Buffer status, request qualification and the MC accept handshake.
  always_comb begin
    headValid        = (count != '0);
    full             = (count == FULL_CNT);
    wbReq            = bus.wb_we && (bus.wb_rd != 5'd0);
    accept           = rst_n && !full && bus.mc_valid;
    bus.mc_ready     = rst_n && !full;
    bus.pend_cnt     = count;
    bus.hazard_stall = rst_n && (busy[bus.rs1] || busy[bus.rs2]);
  end

  // Write-port grant: starved head, then WB, then buffered head, then bypass.
  always_comb begin
    pop         = 1'b0;
    bypass      = 1'b0;
    wbWin       = 1'b0;
    bus.RFWr    = 1'b0;
    bus.WrDtAdr = 5'd0;
    bus.WrDt    = 32'd0;
    bus.wb_hold = 1'b0;
    if (rst_n) begin
      if (headValid && (starve == STARVE_MAX)) begin
        pop         = 1'b1;
        bus.RFWr    = 1'b1;
        bus.WrDtAdr = bufRd[rdPtr];
        bus.WrDt    = bufData[rdPtr];
        bus.wb_hold = wbReq;
      end else if (wbReq) begin
        wbWin       = 1'b1;
        bus.RFWr    = 1'b1;
        bus.WrDtAdr = bus.wb_rd;
        bus.WrDt    = bus.wb_data;
      end else if (headValid) begin
        pop         = 1'b1;
        bus.RFWr    = 1'b1;
        bus.WrDtAdr = bufRd[rdPtr];
        bus.WrDt    = bufData[rdPtr];
      end
`ifdef ARB_BYPASS_EN
      else if (accept && (bus.mc_rd != 5'd0)) begin
        bypass      = 1'b1;
        bus.RFWr    = 1'b1;
        bus.WrDtAdr = bus.mc_rd;
        bus.WrDt    = bus.mc_data;
      end
`endif
    end
  end

  // Push decision and scoreboard set/clear masks; a set on the same rd wins.
  always_comb begin
    push    = accept && (bus.mc_rd != 5'd0) && !bypass;
    setMask = 32'd0;
    clrMask = 32'd0;
    if (bus.mc_issue && (bus.mc_issue_rd != 5'd0)) setMask[bus.mc_issue_rd] = 1'b1;
    if (pop)    clrMask[bufRd[rdPtr]] = 1'b1;
    if (bypass) clrMask[bus.mc_rd]    = 1'b1;
  end

  // Control state: FIFO pointers and occupancy, starvation counter, scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      count  <= '0;
      starve <= '0;
      busy   <= 32'd0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (!headValid || pop)                   starve <= '0;
      else if (wbWin && (starve != STARVE_MAX)) starve <= starve + 1'b1;
      busy <= ((busy & ~clrMask) | setMask) & ~32'd1;
    end
  end

  // Buffer storage: written at the tail on push, read only while valid.
  always_ff @(posedge clk) begin
    if (push) begin
      bufRd[wrPtr]   <= bus.mc_rd;
      bufData[wrPtr] <= bus.mc_data;
    end
  end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed bench for rf_wr_arbiter (DEPTH=2, STARVE_LIMIT=4). Inputs change
// 1 time unit after a rising edge; outputs are checked 1 unit later.
module tb_rf_wr_arbiter;
  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rf_wr_arbiter_if #(.DEPTH(DEPTH)) bus ();

  rf_wr_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wb_we = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'd0;
    bus.mc_issue = 1'b0; bus.mc_issue_rd = 5'd0;
    bus.mc_valid = 1'b0; bus.mc_rd = 5'd0; bus.mc_data = 32'd0;
    bus.rs1 = 5'd0; bus.rs2 = 5'd0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #1;
    if (bus.pend_cnt !== 2'd0) begin errors++; $display("FAIL reset pend_cnt: got %0d expected 0", bus.pend_cnt); end checks++;
    if (bus.mc_ready !== 1'b0) begin errors++; $display("FAIL reset mc_ready: got %0b expected 0", bus.mc_ready); end checks++;
    repeat (2) step();
    rst_n = 1'b1;
    #1;
    if (bus.mc_ready !== 1'b1) begin errors++; $display("FAIL reset release mc_ready: got %0b expected 1", bus.mc_ready); end checks++;
    // Fill the buffer under continuous WB and mark rd 9 busy, then reset mid-stream.
    bus.mc_issue = 1'b1; bus.mc_issue_rd = 5'd9;
    bus.wb_we = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'h1234;
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd7; bus.mc_data = 32'h1;
    step();
    bus.mc_issue = 1'b0;
    bus.mc_rd = 5'd8; bus.mc_data = 32'h2;
    step();
    bus.mc_valid = 1'b0;
    bus.rs1 = 5'd9;
    #1;
    if (bus.pend_cnt !== 2'd2) begin errors++; $display("FAIL midstream pend_cnt: got %0d expected 2", bus.pend_cnt); end checks++;
    if (bus.hazard_stall !== 1'b1) begin errors++; $display("FAIL midstream hazard: got %0b expected 1", bus.hazard_stall); end checks++;
    rst_n = 1'b0;
    #1;
    if (bus.pend_cnt !== 2'd0) begin errors++; $display("FAIL midreset pend_cnt: got %0d expected 0", bus.pend_cnt); end checks++;
    if (bus.RFWr !== 1'b0) begin errors++; $display("FAIL midreset RFWr: got %0b expected 0", bus.RFWr); end checks++;
    if (bus.mc_ready !== 1'b0) begin errors++; $display("FAIL midreset mc_ready: got %0b expected 0", bus.mc_ready); end checks++;
    if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL midreset hazard: got %0b expected 0", bus.hazard_stall); end checks++;
    step();
    rst_n = 1'b1;
    idle();
    bus.rs1 = 5'd9;
    #1;
    if (bus.mc_ready !== 1'b1) begin errors++; $display("FAIL postreset mc_ready: got %0b expected 1", bus.mc_ready); end checks++;
    if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL postreset busy9: got %0b expected 0", bus.hazard_stall); end checks++;
    if (bus.RFWr !== 1'b0) begin errors++; $display("FAIL postreset RFWr: got %0b expected 0", bus.RFWr); end checks++;
    step();
    idle();
  endtask

  task automatic test_wb_only();
    bus.wb_we = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'hDEADBEEF;
    #1;
    if (bus.RFWr !== 1'b1) begin errors++; $display("FAIL wb_only RFWr: got %0b expected 1", bus.RFWr); end checks++;
    if (bus.WrDtAdr !== 5'd5) begin errors++; $display("FAIL wb_only WrDtAdr: got %0d expected 5", bus.WrDtAdr); end checks++;
    if (bus.WrDt !== 32'hDEADBEEF) begin errors++; $display("FAIL wb_only WrDt: got %08h expected deadbeef", bus.WrDt); end checks++;
    if (bus.wb_hold !== 1'b0) begin errors++; $display("FAIL wb_only wb_hold: got %0b expected 0", bus.wb_hold); end checks++;
    bus.wb_rd = 5'd0;
    #1;
    if (bus.RFWr !== 1'b0) begin errors++; $display("FAIL wb_rd0 RFWr: got %0b expected 0", bus.RFWr); end checks++;
    if (bus.wb_hold !== 1'b0) begin errors++; $display("FAIL wb_rd0 wb_hold: got %0b expected 0", bus.wb_hold); end checks++;
    step();
    idle();
  endtask

  task automatic test_contention();
    bus.wb_we = 1'b1; bus.wb_rd = 5'd2; bus.wb_data = 32'hA5A50002;
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd7; bus.mc_data = 32'h11;
    step();
    bus.mc_valid = 1'b0;
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      #1;
      if (bus.WrDtAdr !== 5'd2) begin errors++; $display("FAIL contention wb win %0d WrDtAdr: got %0d expected 2", i, bus.WrDtAdr); end checks++;
      if (bus.wb_hold !== 1'b0) begin errors++; $display("FAIL contention wb win %0d wb_hold: got %0b expected 0", i, bus.wb_hold); end checks++;
      step();
    end
    #1;
    if (bus.WrDtAdr !== 5'd7) begin errors++; $display("FAIL contention forced WrDtAdr: got %0d expected 7", bus.WrDtAdr); end checks++;
    if (bus.WrDt !== 32'h11) begin errors++; $display("FAIL contention forced WrDt: got %08h expected 00000011", bus.WrDt); end checks++;
    if (bus.wb_hold !== 1'b1) begin errors++; $display("FAIL contention forced wb_hold: got %0b expected 1", bus.wb_hold); end checks++;
    step();
    if (bus.WrDtAdr !== 5'd2) begin errors++; $display("FAIL contention rewrite WrDtAdr: got %0d expected 2", bus.WrDtAdr); end checks++;
    if (bus.wb_hold !== 1'b0) begin errors++; $display("FAIL contention rewrite wb_hold: got %0b expected 0", bus.wb_hold); end checks++;
    if (bus.pend_cnt !== 2'd0) begin errors++; $display("FAIL contention pend_cnt: got %0d expected 0", bus.pend_cnt); end checks++;
    idle();
    step();
  endtask

  task automatic test_full();
    bit found = 1'b0;
    bus.wb_we = 1'b1; bus.wb_rd = 5'd2; bus.wb_data = 32'h2222;
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd10; bus.mc_data = 32'h100;
    step();
    bus.mc_rd = 5'd11; bus.mc_data = 32'h101;
    step();
    bus.mc_rd = 5'd12; bus.mc_data = 32'h102;
    #1;
    if (bus.mc_ready !== 1'b0) begin errors++; $display("FAIL full mc_ready: got %0b expected 0", bus.mc_ready); end checks++;
    if (bus.pend_cnt !== 2'd2) begin errors++; $display("FAIL full pend_cnt: got %0d expected 2", bus.pend_cnt); end checks++;
    for (int i = 0; i < 10; i++) begin
      if (bus.RFWr && bus.WrDtAdr == 5'd10) begin found = 1'b1; break; end
      if (bus.pend_cnt !== 2'd2) begin errors++; $display("FAIL full held pend_cnt: got %0d expected 2", bus.pend_cnt); end checks++;
      step();
    end
    if (!found) begin errors++; $display("FAIL full forced pop: got none expected rd 10 within 10 cycles"); end checks++;
    if (bus.WrDt !== 32'h100) begin errors++; $display("FAIL full pop WrDt: got %08h expected 00000100", bus.WrDt); end checks++;
    if (bus.mc_ready !== 1'b0) begin errors++; $display("FAIL full pop-cycle mc_ready: got %0b expected 0", bus.mc_ready); end checks++;
    step();
    if (bus.mc_ready !== 1'b1) begin errors++; $display("FAIL full after pop mc_ready: got %0b expected 1", bus.mc_ready); end checks++;
    step();
    idle();
    #1;
    if (bus.pend_cnt !== 2'd2) begin errors++; $display("FAIL full refill pend_cnt: got %0d expected 2", bus.pend_cnt); end checks++;
    if (bus.WrDtAdr !== 5'd11 || bus.WrDt !== 32'h101) begin errors++; $display("FAIL full drain1: got %0d/%08h expected 11/00000101", bus.WrDtAdr, bus.WrDt); end checks++;
    step();
    if (bus.WrDtAdr !== 5'd12 || bus.WrDt !== 32'h102) begin errors++; $display("FAIL full drain2: got %0d/%08h expected 12/00000102", bus.WrDtAdr, bus.WrDt); end checks++;
    step();
    if (bus.pend_cnt !== 2'd0) begin errors++; $display("FAIL full drained pend_cnt: got %0d expected 0", bus.pend_cnt); end checks++;
    if (bus.RFWr !== 1'b0) begin errors++; $display("FAIL full drained RFWr: got %0b expected 0", bus.RFWr); end checks++;
  endtask

  task automatic test_scoreboard();
    idle();
    bus.rs1 = 5'd9;
    bus.mc_issue = 1'b1; bus.mc_issue_rd = 5'd9;
    #1;
    if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL sb before set: got %0b expected 0", bus.hazard_stall); end checks++;
    step();
    bus.mc_issue = 1'b0;
    #1;
    if (bus.hazard_stall !== 1'b1) begin errors++; $display("FAIL sb busy: got %0b expected 1", bus.hazard_stall); end checks++;
    bus.wb_we = 1'b1; bus.wb_rd = 5'd2; bus.wb_data = 32'h2;
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd9; bus.mc_data = 32'h99;
    step();
    bus.wb_we = 1'b0; bus.mc_valid = 1'b0;
    #1;
    if (bus.RFWr !== 1'b1 || bus.WrDtAdr !== 5'd9) begin errors++; $display("FAIL sb pop rd9: got %0b/%0d expected 1/9", bus.RFWr, bus.WrDtAdr); end checks++;
    if (bus.hazard_stall !== 1'b1) begin errors++; $display("FAIL sb busy during pop: got %0b expected 1", bus.hazard_stall); end checks++;
    step();
    if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL sb cleared: got %0b expected 0", bus.hazard_stall); end checks++;
    bus.rs1 = 5'd0; bus.rs2 = 5'd0;
    bus.mc_issue = 1'b1; bus.mc_issue_rd = 5'd0;
    step();
    bus.mc_issue = 1'b0;
    #1;
    if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL sb rd0 issue: got %0b expected 0", bus.hazard_stall); end checks++;
    // Issue rd 9 again in the same cycle its previous result is popped.
    bus.mc_issue = 1'b1; bus.mc_issue_rd = 5'd9;
    step();
    bus.mc_issue = 1'b0;
    bus.wb_we = 1'b1; bus.wb_rd = 5'd2;
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd9; bus.mc_data = 32'h98;
    step();
    bus.wb_we = 1'b0; bus.mc_valid = 1'b0;
    bus.mc_issue = 1'b1; bus.mc_issue_rd = 5'd9;
    #1;
    if (bus.WrDtAdr !== 5'd9) begin errors++; $display("FAIL sb set-wins pop: got %0d expected 9", bus.WrDtAdr); end checks++;
    step();
    bus.mc_issue = 1'b0;
    bus.rs2 = 5'd9;
    #1;
    if (bus.hazard_stall !== 1'b1) begin errors++; $display("FAIL sb set wins: got %0b expected 1", bus.hazard_stall); end checks++;
    bus.wb_we = 1'b1;
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd9; bus.mc_data = 32'h97;
    step();
    bus.wb_we = 1'b0; bus.mc_valid = 1'b0;
    step();
    if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL sb final clear: got %0b expected 0", bus.hazard_stall); end checks++;
    idle();
    step();
  endtask

  task automatic test_bypass();
    idle();
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd3; bus.mc_data = 32'h55;
    #1;
`ifdef ARB_BYPASS_EN
    if (bus.RFWr !== 1'b1 || bus.WrDtAdr !== 5'd3 || bus.WrDt !== 32'h55) begin errors++; $display("FAIL bypass same cycle: got %0b/%0d/%08h expected 1/3/00000055", bus.RFWr, bus.WrDtAdr, bus.WrDt); end checks++;
    step();
    bus.mc_valid = 1'b0;
    #1;
    if (bus.pend_cnt !== 2'd0) begin errors++; $display("FAIL bypass pend_cnt: got %0d expected 0", bus.pend_cnt); end checks++;
    if (bus.RFWr !== 1'b0) begin errors++; $display("FAIL bypass no replay: got %0b expected 0", bus.RFWr); end checks++;
`else
    if (bus.RFWr !== 1'b0) begin errors++; $display("FAIL nobypass same cycle RFWr: got %0b expected 0", bus.RFWr); end checks++;
    step();
    bus.mc_valid = 1'b0;
    #1;
    if (bus.RFWr !== 1'b1 || bus.WrDtAdr !== 5'd3 || bus.WrDt !== 32'h55) begin errors++; $display("FAIL nobypass next cycle: got %0b/%0d/%08h expected 1/3/00000055", bus.RFWr, bus.WrDtAdr, bus.WrDt); end checks++;
    if (bus.pend_cnt !== 2'd1) begin errors++; $display("FAIL nobypass pend_cnt: got %0d expected 1", bus.pend_cnt); end checks++;
    step();
    if (bus.pend_cnt !== 2'd0) begin errors++; $display("FAIL nobypass drained: got %0d expected 0", bus.pend_cnt); end checks++;
`endif
    idle();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_wb_only();
    test_contention();
    test_full();
    test_scoreboard();
    test_bypass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
